// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: steps the external round datapath through AddRoundKey, 9 full rounds and the final round.
// Optional AES_SELFCHECK_EN: after an encrypt job, an automatic decrypt pass runs and the recovered plaintext is compared.
`timescale 1ns/1ps
module aes_round_sequencer #(
    parameter int NROUNDS = 10,
    parameter int TIMEOUT = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_decrypt,
    output logic       rnd_go,
    output logic [3:0] rnd_idx,
    output logic [1:0] rnd_kind,
    output logic       rnd_dec,
    output logic [7:0] rcon,
    input  logic       rnd_done,
    output logic       busy,
    output logic       rsp_valid,
    input  logic       rsp_ready,
`ifdef AES_SELFCHECK_EN
    input  logic       cmp_match,
    output logic       chk_fail,
`endif
    output logic       rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LAST_IDX   = 4'(NROUNDS);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [1:0] KIND_ARK   = 2'd0;
    localparam logic [1:0] KIND_FULL  = 2'd1;
    localparam logic [1:0] KIND_FINAL = 2'd2;

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic [1:0] kind_reg, kind_next;
    logic       dec_reg, dec_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       err_reg, err_next;
`ifdef AES_SELFCHECK_EN
    logic       self_reg, self_next;
    logic       chk_reg, chk_next;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            kind_reg  <= KIND_ARK;
            dec_reg   <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
`ifdef AES_SELFCHECK_EN
            self_reg  <= 1'b0;
            chk_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            kind_reg  <= kind_next;
            dec_reg   <= dec_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
`ifdef AES_SELFCHECK_EN
            self_reg  <= self_next;
            chk_reg   <= chk_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        kind_next  = kind_reg;
        dec_next   = dec_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`ifdef AES_SELFCHECK_EN
        self_next  = self_reg;
        chk_next   = chk_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    // Decrypt walks the key schedule backwards, starting from the last round key
                    dec_next   = req_decrypt;
                    idx_next   = req_decrypt ? LAST_IDX : 4'd0;
                    kind_next  = KIND_ARK;
                    err_next   = 1'b0;
`ifdef AES_SELFCHECK_EN
                    self_next  = 1'b0;
                    chk_next   = 1'b0;
`endif
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (rnd_done) begin
                    if (kind_reg == KIND_FINAL) begin
`ifdef AES_SELFCHECK_EN
                        if (!dec_reg) begin
                            dec_next   = 1'b1;
                            idx_next   = LAST_IDX;
                            kind_next  = KIND_ARK;
                            self_next  = 1'b1;
                            state_next = S_ISSUE;
                        end else begin
                            chk_next   = self_reg & ~cmp_match;
                            state_next = S_RESP;
                        end
`else
                        state_next = S_RESP;
`endif
                    end else begin
                        idx_next   = dec_reg ? idx_reg - 4'd1 : idx_reg + 4'd1;
                        kind_next  = (dec_reg ? (idx_reg == 4'd1) : (idx_reg == LAST_IDX - 4'd1))
                                     ? KIND_FINAL : KIND_FULL;
                        state_next = S_ISSUE;
                    end
                end else if (cnt_reg == TMO_LAST) begin
                    // A done pulse on this same cycle takes priority above, so it is not an error
                    cnt_next   = cnt_reg + 8'd1;
                    err_next   = 1'b1;
`ifdef AES_SELFCHECK_EN
                    chk_next   = 1'b0;
`endif
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    err_next   = 1'b0;
`ifdef AES_SELFCHECK_EN
                    chk_next   = 1'b0;
`endif
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Rcon is the GF(2^8) power x^(idx-1); index 0 has no key-schedule step
    always_comb begin
        case (idx_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign req_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign rnd_go    = (state_reg == S_ISSUE);
    assign rsp_valid = (state_reg == S_RESP);
    assign rnd_idx   = idx_reg;
    assign rnd_kind  = kind_reg;
    assign rnd_dec   = dec_reg;
    assign rsp_err   = err_reg;
`ifdef AES_SELFCHECK_EN
    assign chk_fail  = chk_reg;
`endif

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM that sequences the AES-128 round datapath (byte-wide ptext/key/ctext/rec lanes) through initial AddRoundKey, 9 full rounds and the final round.
- Accepts one encrypt/decrypt job via valid/ready, drives round index, Rcon and round-kind strobes, and handshakes each round with the datapath.
- Returns completion via valid/ready.
- Sits between the host/bus wrapper and the AES datapath; the datapath holds all 128-bit state.

Parameters:
- NROUNDS, 10, total rounds after the initial AddRoundKey (AES-128).
- TIMEOUT, 255, max cycles to wait for rnd_done before aborting; 8-bit counter.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous active-high reset
- req_valid  in  1  job request
- req_ready  out  1  sequencer can accept a job
- req_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- rnd_go  out  1  one-cycle pulse: datapath starts the step described by rnd_idx/rnd_kind
- rnd_idx  out  4  current round number, 0..NROUNDS
- rnd_kind  out  2  0 = initial AddRoundKey, 1 = full round, 2 = final round (no MixColumns)
- rnd_dec  out  1  latched req_decrypt
- rcon  out  8  round constant for the key-schedule step of rnd_idx
- rnd_done  in  1  datapath completes the step; one-cycle pulse
- busy  out  1  high in any state except IDLE
- rsp_valid  out  1  job finished; result in datapath
- rsp_ready  in  1  consumer takes the result
- rsp_err  out  1  valid with rsp_valid: the job aborted on timeout

Behaviour:
- Reset values (async, immediate): state IDLE, req_ready 1, rnd_go 0, rnd_idx 0, rnd_kind 0, rnd_dec 0, rcon 8'h00, busy 0, rsp_valid 0, rsp_err 0, timeout counter 0.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch rnd_dec.
  - rnd_idx = 0 for encrypt, NROUNDS for decrypt (the key schedule runs in reverse).
  - Go to ISSUE.
  - A request is never accepted in the same cycle as rsp_valid.
- ISSUE:
  - rnd_go = 1 for exactly one cycle.
  - rnd_kind:
    - 0 when the step is the first of the job.
    - 2 when it is the last (encrypt idx == NROUNDS; decrypt idx == 0).
    - Otherwise 1.
  - For decrypt, the first step is AddRoundKey with round key NROUNDS: kind 0. The last step is kind 2 with idx 0.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - Hold rnd_idx, rnd_kind, rcon stable.
  - On rnd_done:
    - If this was the last step, go to RESP with rsp_err 0.
    - Otherwise step rnd_idx (encrypt +1, decrypt -1) and go to ISSUE.
  - The counter increments each cycle without rnd_done. When it reaches TIMEOUT, go to RESP with rsp_err 1.
  - If rnd_done arrives in the same cycle the counter reaches TIMEOUT, it counts as done (no error).
- Latency: one step = 1 ISSUE cycle + datapath latency. A full job takes NROUNDS+1 steps.
- rcon is combinational from rnd_idx:
  - idx 1..10 → 01,02,04,08,10,20,40,80,1B,36.
  - idx 0 → 00.
  - Identical for decrypt; the datapath uses it for the inverse key step.
- RESP:
  - rsp_valid held until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE, rsp_valid 0, rsp_err 0.
  - rsp_ready while not valid is ignored.
- rnd_done outside WAIT is ignored; no state change.
- busy = (state != IDLE).
- sys_rst mid-job: abort immediately to the reset values. Any datapath step in flight is abandoned. A late rnd_done after reset is ignored.

Optional Feature:
- Macro: AES_SELFCHECK_EN.
- Defined:
  - After a successful encrypt job, the sequencer runs a full decrypt pass automatically (rnd_dec = 1, same rules) before RESP.
  - Adds input cmp_match (1 bit), asserted by the datapath when rec equals ptext. It is sampled on the final decrypt rnd_done.
  - Adds output chk_fail (1 bit), valid with rsp_valid: 1 if cmp_match was 0. Reset value 0.
  - A timeout in either pass sets rsp_err and skips the check (chk_fail 0).
- Not defined: no extra ports; an encrypt job ends after NROUNDS+1 steps.

Test Plan:
- Encrypt job, datapath answers rnd_done 2 cycles after each rnd_go → 11 rnd_go pulses.
  - rnd_idx 0..10; kinds 0, then 1×9, then 2; rcon 00,01,...,36.
  - rsp_valid with rsp_err 0; busy falls after the rsp handshake.
- Decrypt job → rnd_idx 10 down to 0, kind 0 first and kind 2 last; rcon sequence 36,1B,80,...,01,00.
- Datapath never answers on round 3 → rsp_valid with rsp_err 1, 255 cycles after that rnd_go. A late rnd_done afterwards causes no change.
- rsp_ready held low 20 cycles with req_valid high:
  - rsp_valid stays 1 and req_ready stays 0.
  - The next job is accepted 1 cycle after the handshake.
- Assert sys_rst during round 5 → all outputs return to their reset values immediately. A new job then starts at rnd_idx 0.
- AES_SELFCHECK_EN: encrypt with cmp_match 1 → 22 rnd_go pulses, chk_fail 0. Repeat with cmp_match 0 → chk_fail 1.
